data_memory_bank: RTL
=====================

# data_memory_bank

Parametrised, byte-addressable data memory for the MIPS datapath, replacing the fixed 64K-word array with word-only enables. It accepts one load or store at a time over a valid/ready request channel and returns a response over a valid/ready response channel. It handles byte, halfword and word accesses with lane steering, sign or zero extension on loads, configurable read latency, and error reporting for misaligned or out-of-range accesses. It sits between the MEM stage / load-store logic and the storage array.

## Interface
- ADDR_WIDTH, 18, byte-address bits decoded; depth = 2^(ADDR_WIDTH-2) words
- READ_LATENCY, 2, cycles from load accept to rsp_valid; legal 1..4
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load data, extended; 0 for stores and errors
- rsp_err  out  1  access rejected (misaligned, out of range, or size 11)

## Operation
- States: IDLE, READ_WAIT, RESP. req_ready = (state == IDLE).
- Accept: req_valid & req_ready.
- Error check at accept:
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - size 11
  - any addr[31:ADDR_WIDTH] != 0
- Error -> no memory access, go to RESP with rsp_err = 1 and rsp_rdata = 0.
- Store, no error: write on the accept edge.
  - Byte enables: byte -> 1 << addr[1:0]; half -> 0011 or 1100 by addr[1]; word -> 1111.
  - wdata replicated across lanes (byte x4, half x2) so the enabled lanes get the correct bytes.
  - Go to RESP with rsp_err = 0 and rsp_rdata = 0.
- Load, no error: synchronous array read, then count READ_LATENCY-1 cycles in READ_WAIT (skipped if READ_LATENCY = 1).
  - Select the lane by addr[1:0]/size, extend per req_signed, register into rsp_rdata, go to RESP.
- Request fields (addr[1:0], size, signed) are captured at accept; inputs may change afterwards.
- RESP: hold rsp_valid and data stable until rsp_ready; on handshake go to IDLE.
- Only one request is outstanding; no reordering.
- Memory contents are not reset and are not initialised.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, latency counter 0.
- Store accepted at edge T: array updated at T; rsp_valid high from T+1.
- Load accepted at T: rsp_valid high from T+READ_LATENCY.
- Error accepted at T: rsp_valid high from T+1.
- rsp_ready held high: the response completes in its first valid cycle; req_ready returns the following cycle. Throughput is 1 store per 2 cycles and 1 load per READ_LATENCY+1 cycles.
- Read-after-write: a load accepted after a store's response returns the new data.
- Reset asserted mid-load: the load is aborted and no response is issued. A store already accepted stays committed.
- rsp_ready asserted while rsp_valid is low has no effect.

## Structure
- Package dmem_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and a byte-enable function.
- Sub-module dmem_align (combinational) takes size, addr[1:0], wdata, raw word and signed. It produces byte enables, replicated write data and extended load data.
- The top level owns the FSM, latency counter, response registers and storage array.

## Test plan
- After reset: req_ready = 1, rsp_valid = 0. Store word 0xDEADBEEF @0x10, then load word @0x10 with READ_LATENCY = 2 -> rsp_valid 2 cycles after accept, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Store byte 0x80 @0x13, load signed byte @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word @0x10 -> 0x80ADBEEF.
- Store half 0x1234 @0x22, load signed half @0x22 -> 0x00001234, word @0x20 -> 0x1234xxxx with the lower half unchanged.
- Load word @0x11, load half @0x21, size 11, and address 0x0004_0000 (ADDR_WIDTH = 18) -> each gives rsp_err = 1 and rsp_rdata = 0 one cycle after accept, with no memory change.
- Hold rsp_ready low for 5 cycles -> rsp_valid and data stay stable and req_ready stays 0. Release -> req_ready = 1 on the next cycle.
- Drop rst_n during READ_WAIT -> no rsp_valid is issued, state is IDLE, and a prior stored value is still readable.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM states and byte-enable helper for the data memory bank
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ_WAIT,
        ST_RESP
    } state_t;

    // Lanes touched by an access of the given size at byte offset lane.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << lane;
            SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - lane steering for stores and lane select plus extension for loads
//   size, lane      : access size and byte offset within the word
//   wdata           : right-justified store data
//   raw_word        : word read from the array
//   sign_ext        : 1 sign-extends loaded bytes/halves
//   be, wdata_rep   : byte enables and lane-replicated store data
//   rdata_ext       : selected and extended load data (0 for illegal size)
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    input  logic        sign_ext,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        be        = byte_en(size, lane);
        wdata_rep = '0;
        rdata_ext = '0;
        sel_byte  = raw_word[{lane, 3'b000} +: 8];
        sel_half  = raw_word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sign_ext & sel_half[15]}}, sel_half};
            end
            SZ_WORD: begin
                wdata_rep = wdata;
                rdata_ext = raw_word;
            end
            default: begin
                wdata_rep = '0;
                rdata_ext = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_bank.sv
// rtl/data_memory_bank.sv - byte-addressable data memory with valid/ready request and response channels
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready             : request handshake (ready only in IDLE)
//   req_we, req_size, req_signed    : store/load, access size, load extension
//   req_addr, req_wdata             : byte address, right-justified store data
//   rsp_valid/rsp_ready             : response handshake
//   rsp_rdata, rsp_err              : extended load data (0 for stores/errors), access rejected
module data_memory_bank
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 18,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH    = 1 << (ADDR_WIDTH - 2);
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    logic [31:0] mem [DEPTH];

    state_t                  state, next_state;
    logic                    accept;
    logic                    req_err;
    logic [ADDR_WIDTH-3:0]   req_idx;
    logic [1:0]              cnt;
    logic [1:0]              cap_size;
    logic [1:0]              cap_lane;
    logic                    cap_signed;
    logic [31:0]             rd_word;

    logic                    sel_req;
    logic [1:0]              al_size;
    logic [1:0]              al_lane;
    logic                    al_signed;
    logic [31:0]             al_raw;
    logic [3:0]              be;
    logic [31:0]             wdata_rep;
    logic [31:0]             rdata_ext;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;
    assign req_idx   = req_addr[ADDR_WIDTH-1:2];

    always_comb begin
        req_err = 1'b0;
        if ((req_addr >> ADDR_WIDTH) != 32'd0)                req_err = 1'b1;
        if (req_size == 2'b11)                                req_err = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])               req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)    req_err = 1'b1;
    end

    // In IDLE the aligner sees the live request (store steering, and the
    // single-cycle load path); afterwards it sees the captured load fields.
    // Only a latency of 1 reads the array combinationally.
    assign sel_req   = (state == ST_IDLE);
    assign al_size   = sel_req ? req_size   : cap_size;
    assign al_lane   = sel_req ? req_addr[1:0] : cap_lane;
    assign al_signed = sel_req ? req_signed : cap_signed;
    assign al_raw    = sel_req ? ((READ_LATENCY == 1) ? mem[req_idx] : 32'd0) : rd_word;

    dmem_align u_align (
        .size      (al_size),
        .lane      (al_lane),
        .wdata     (req_wdata),
        .raw_word  (al_raw),
        .sign_ext  (al_signed),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err || req_we || READ_LATENCY == 1) next_state = ST_RESP;
                    else                                         next_state = ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: if (cnt == LAT_LAST) next_state = ST_RESP;
            ST_RESP:      if (rsp_ready)       next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 2'd0;
            cap_size   <= SZ_BYTE;
            cap_lane   <= 2'd0;
            cap_signed <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else if (accept) begin
            cnt        <= 2'd1;
            cap_size   <= req_size;
            cap_lane   <= req_addr[1:0];
            cap_signed <= req_signed;
            rsp_err    <= req_err;
            rsp_rdata  <= (!req_err && !req_we && READ_LATENCY == 1) ? rdata_ext : 32'd0;
        end else if (state == ST_READ_WAIT) begin
            if (cnt == LAT_LAST) rsp_rdata <= rdata_ext;
            else                 cnt       <= cnt + 2'd1;
        end
    end

    // Storage is never reset; a store commits on its accept edge.
    always_ff @(posedge clk) begin
        if (accept && !req_err) begin
            if (req_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[req_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end else begin
                rd_word <= mem[req_idx];
            end
        end
    end

endmodule
